// File: rtl/mag16_cordic.sv
// I/Q magnitude sqrt(x^2+y^2) via CORDIC vectoring and 1/K gain compensation.
// Latency STAGES+3 clocks, one sample per clock; no backpressure, ov is iv delayed.
module mag16_cordic #(
  parameter int STAGES = 12,
  parameter int GUARD  = 2,
  parameter int KGAIN  = 39797
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        iv,
  output logic [15:0] m,
  output logic        ov
);

  localparam int W  = 17 + GUARD + 1;
  localparam int PW = (W - 1) + 16;
  localparam int RS = GUARD + 16;
  localparam logic [15:0] KG = 16'(KGAIN);

  logic [16:0]         w_ax;
  logic [16:0]         w_ay;
  logic [PW-1:0]       w_round;
  logic                w_unused;

  logic signed [W-1:0] r_x [0:STAGES];
  logic signed [W-1:0] r_y [0:STAGES];
  logic [PW-1:0]       r_p;
  logic [STAGES+2:0]   r_v;

  // 17-bit magnitudes keep |-32768| exact
  assign w_ax = x[15] ? (17'd0 - {1'b1, x}) : {1'b0, x};
  assign w_ay = y[15] ? (17'd0 - {1'b1, y}) : {1'b0, y};

  always_ff @(posedge clk) begin
    r_x[0] <= $signed({1'b0, w_ax, {GUARD{1'b0}}});
    r_y[0] <= $signed({1'b0, w_ay, {GUARD{1'b0}}});
    for (int i = 0; i < STAGES; i++) begin
      if (!r_y[i][W-1]) begin
        r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
        r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
      end else begin
        r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
        r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
      end
    end
    // X stays non-negative through vectoring, so the sign bit is dropped
    r_p <= PW'(r_x[STAGES][W-2:0]) * PW'(KG);
  end

  assign w_round = r_p + (PW'(1) << (RS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      m   <= '0;
    end else begin
      r_v <= {r_v[STAGES+1:0], iv};
      if (r_v[STAGES+1]) begin
        m <= w_round[RS +: 16];
      end
    end
  end

  assign ov = r_v[STAGES+2];

  assign w_unused = ^{r_y[STAGES], r_x[STAGES][W-1], w_round[RS-1:0], w_round[PW-1:RS+16]};

endmodule

// File: tb/tb_mag16_cordic.sv
// Directed + random bench for mag16_cordic with a queue scoreboard.
`timescale 1ns/1ps
module tb_mag16_cordic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x   = '0;
  logic [15:0] y   = '0;
  logic        iv  = 1'b0;
  logic [15:0] m;
  logic        ov;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_iv   = 0;
  int n_ov   = 0;
  int q_exp[$];
  int q_cyc[$];

  mag16_cordic dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .iv  (iv),
    .m   (m),
    .ov  (ov)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_mag(input int a, input int b);
    real r;
    r = $sqrt(real'(a) * real'(a) + real'(b) * real'(b));
    return $rtoi(r + 0.5);
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int expv);
    logic ok;
    ok = ((obs - expv) <= 2) && ((expv - obs) <= 2);
    n_chk++;
    assert (ok === 1'b1) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0d, want %0d +-2", tag, obs, expv);
    end
  endtask

  task automatic send(input int a, input int b);
    @(negedge clk);
    x  = 16'(a);
    y  = 16'(b);
    iv = 1'b1;
    q_exp.push_back(ref_mag(a, b));
    q_cyc.push_back(cyc + 15);
    n_iv++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv = 1'b0;
    end
  endtask

  // Output side of the scoreboard: every ov must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && ov) begin
      n_ov++;
      if (q_exp.size() == 0) begin
        chk_eq("ov_without_pending_sample", q_exp.size(), 1);
      end else begin
        int e;
        int c;
        e = q_exp.pop_front();
        c = q_cyc.pop_front();
        chk_eq("latency_cycle", cyc, c);
        chk_tol("magnitude", int'(m), e);
      end
    end
  end

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    chk_eq("reset_m", int'(m), 0);
    chk_eq("reset_ov", int'(ov), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_eq("idle_ov", int'(ov), 0);
    end
    chk_eq("idle_m", int'(m), 0);

    // Single samples, each followed by a full drain
    send(10000, 0);      idle(16);
    chk_tol("m_hold", int'(m), 10000);
    send(0, 1000);       idle(16);
    send(7071, 7071);    idle(16);
    send(10000, 10000);  idle(16);
    send(3000, 4000);    idle(16);
    send(-3000, -4000);  idle(16);
    send(-32768, -32768); idle(16);
    send(0, 0);          idle(16);
    chk_eq("zero_m", int'(m), 0);
    send(-32768, 0);     idle(16);
    send(0, -32768);     idle(16);
    send(32767, -32768); idle(16);

    // Back-to-back burst
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(65535) - 32768, $urandom_range(65535) - 32768);
    end
    idle(20);
    chk_eq("burst_drained", q_exp.size(), 0);

    // Reset with three samples in flight
    send(12000, 5000);
    send(-20000, 1000);
    send(300, -30000);
    idle(4);
    @(negedge clk);
    rst = 1'b1;
    n_iv -= q_exp.size();
    q_exp.delete();
    q_cyc.delete();
    repeat (2) @(negedge clk);
    chk_eq("midreset_m", int'(m), 0);
    chk_eq("midreset_ov", int'(ov), 0);
    rst = 1'b0;
    idle(20);
    chk_eq("after_reset_m", int'(m), 0);
    send(-6000, 8000);   idle(16);
    chk_tol("post_reset_m", int'(m), 10000);

    // Random traffic with gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) != 0) begin
        send($urandom_range(65535) - 32768, $urandom_range(65535) - 32768);
      end else begin
        idle(1);
      end
    end
    idle(20);

    chk_eq("final_queue_empty", q_exp.size(), 0);
    chk_eq("ov_count", n_ov, n_iv);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
